fft_ctrl_regfile: RTL
=====================

# fft_ctrl_regfile

Parametrised control/status register file for the FFT engine: generalises the single-bit start register to an addressed bank of NUM_REGS DATA_W-bit registers with a read/write handshake. Provides a self-clearing start pulse, sticky done/error status with write-1-to-clear, an interrupt output, and a set of configuration registers driven straight to the datapath. It sits between the host bus bridge and the FFT core.

## Interface

Parameters:
- DATA_W, 32, register width; must be ≥ 3.
- NUM_REGS, 4, number of registers; must be ≥ 3. Map: addr 0 = CTRL, addr 1 = STATUS, addr 2..NUM_REGS-1 = CFG.
- ADDR_W, 2, address width; must be ≥ clog2(NUM_REGS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wen  in  1  write request, single cycle.
- ren  in  1  read request, single cycle.
- addr  in  ADDR_W  register address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid while ready is high after a read.
- ready  out  1  request-completed strobe.
- fft_busy  in  1  FFT core is running.
- fft_done  in  1  single-cycle completion pulse from the core.
- start_pulse  out  1  one-cycle FFT start.
- cfg_q  out  (NUM_REGS-2)*DATA_W  CFG registers flattened; CFG at addr k occupies bits [(k-2)*DATA_W +: DATA_W].
- irq  out  1  interrupt, level.

## Operation

- CTRL layout:
  - bit0 START: write-only, reads 0.
  - bit1 IRQ_EN: read/write.
  - other bits read 0.
- STATUS layout:
  - bit0 BUSY: live copy of fft_busy, read-only.
  - bit1 DONE: sticky, W1C.
  - bit2 ERR: sticky, W1C.
  - other bits read 0; writes to bit0 are ignored.
- CFG registers: plain read/write, full width.
- Write (wen=1), committed at the clock edge:
  - CTRL: IRQ_EN <= wdata[1]. If wdata[0]=1 and fft_busy=0, start_pulse=1 on the next cycle. If wdata[0]=1 and fft_busy=1, there is no pulse and ERR is set.
  - STATUS: writing 1 to bit1 clears DONE; writing 1 to bit2 clears ERR.
  - CFG: the register takes wdata.
  - Address ≥ NUM_REGS: write is discarded.
- Read (ren=1 and wen=0): rdata <= the addressed register's read view. Out-of-range address returns 0.
- wen and ren in the same cycle: the write wins and the read is dropped. Ready is still generated once.
- DONE is set by fft_done. If fft_done coincides with a W1C of DONE, the set wins (DONE stays 1). The same set-over-clear rule applies to ERR when a start-while-busy error coincides with an ERR clear.
- irq = IRQ_EN & DONE, registered (one cycle after either term changes).
- Reset values:
  - All registers 0.
  - rdata, ready, start_pulse and irq are all 0.

## Timing

- Request at edge N, then ready=1 during cycle N+1 for exactly one cycle. Every accepted request (wen or ren) produces one ready. Back-to-back requests every cycle are allowed and produce ready on consecutive cycles.
- Read data: rdata is registered and valid in the same cycle as ready. In every cycle without a read completion, rdata = 0.
- Write visibility: register contents and cfg_q update one cycle after the wen edge. A read issued in the next cycle returns the new value.
- start_pulse is high in exactly the cycle after the CTRL write and is never longer than one cycle. A new START written while start_pulse is still high is accepted only if fft_busy=0.
- BUSY read view samples fft_busy at the read edge.
- Asynchronous reset mid-operation clears everything immediately: an in-flight ready/start_pulse is lost, and no late ready appears after rst_n is released.

## Test plan

- Reset, then read all addresses 0..3. Required: each read gives ready one cycle later with rdata=0; irq=0 and start_pulse=0 throughout.
- Write CFG addr 2 = 0xDEADBEEF, then read addr 2 back-to-back. Required: cfg_q[31:0]=0xDEADBEEF one cycle after the write; the read returns 0xDEADBEEF; there are two ready pulses on consecutive cycles.
- Write CTRL = 0x3 with fft_busy=0, then drive fft_done for one cycle. Required:
  - start_pulse high for 1 cycle.
  - STATUS read = 0x2.
  - irq=1 one cycle after DONE sets.
  - Writing STATUS = 0x2 clears DONE and drops irq.
- Write CTRL = 0x1 while fft_busy=1. Required: no start_pulse; STATUS read = 0x5; writing 0x4 to STATUS then gives STATUS read = 0x1.
- Same cycle wen=1/ren=1 to addr 3 with wdata=0x12, and separately fft_done coinciding with a DONE W1C. Required:
  - CFG3 = 0x12, a single ready pulse, rdata=0.
  - DONE remains 1 after the coincident fft_done/W1C.
- Write to addr 3 with NUM_REGS=3, and assert rst_n low one cycle after a ren. Required: the write is ignored and the read returns 0; no ready is seen after rst_n releases.

Source files
------------

// File: rtl/fft_ctrl_regfile_if.sv
// Host-side register bus for the FFT control/status register file.
// Single-cycle wen/ren requests; ready strobes once per accepted request.
interface fft_ctrl_regfile_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 2
);
   logic              wen;
   logic              ren;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (
      output wen, ren, addr, wdata,
      input  rdata, ready
   );

   modport slave (
      input  wen, ren, addr, wdata,
      output rdata, ready
   );
endinterface

// File: rtl/fft_ctrl_regfile.sv
// FFT control/status register file: CTRL (start, irq enable), sticky STATUS with W1C,
// and NUM_REGS-2 plain CFG registers driven straight to the datapath.
module fft_ctrl_regfile #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned ADDR_W   = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   fft_ctrl_regfile_if.slave                bus,
   input  logic                             i_fft_busy,
   input  logic                             i_fft_done,
   output logic                             o_start_pulse,
   output logic [(NUM_REGS-2)*DATA_W-1:0]   o_cfg_q,
   output logic                             o_irq
);

   localparam int unsigned NumCfg = NUM_REGS - 2;

   logic [31:0]       w_addr;
   logic              w_wr_ctrl;
   logic              w_wr_status;
   logic              w_start_ok;
   logic              w_start_err;
   logic              w_clr_done;
   logic              w_clr_err;
   logic [DATA_W-1:0] w_view;
   logic [DATA_W-1:0] w_cfg_or [NumCfg+1];

   logic              r_irq_en;
   logic              r_done;
   logic              r_err;
   logic              r_irq;
   logic              r_start_pulse;
   logic              r_ready;
   logic [DATA_W-1:0] r_rdata;

   assign w_addr      = 32'(bus.addr);
   assign w_wr_ctrl   = bus.wen && (w_addr == 32'd0);
   assign w_wr_status = bus.wen && (w_addr == 32'd1);
   assign w_start_ok  = w_wr_ctrl && bus.wdata[0] && !i_fft_busy;
   assign w_start_err = w_wr_ctrl && bus.wdata[0] && i_fft_busy;
   assign w_clr_done  = w_wr_status && bus.wdata[1];
   assign w_clr_err   = w_wr_status && bus.wdata[2];

   // Each CFG register ORs its value into the read chain only when addressed.
   assign w_cfg_or[0] = '0;
   for (genvar g = 0; g < NumCfg; g++) begin : g_cfg
      logic              w_hit;
      logic [DATA_W-1:0] r_cfg;

      assign w_hit = (w_addr == 32'(g + 2));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cfg <= '0;
         end else if (bus.wen && w_hit) begin
            r_cfg <= bus.wdata;
         end
      end

      assign w_cfg_or[g+1]                = w_cfg_or[g] | (w_hit ? r_cfg : '0);
      assign o_cfg_q[g*DATA_W +: DATA_W]  = r_cfg;
   end

   always_comb begin
      w_view = w_cfg_or[NumCfg];
      if (w_addr == 32'd0) begin
         w_view    = '0;
         w_view[1] = r_irq_en;
      end else if (w_addr == 32'd1) begin
         w_view    = '0;
         w_view[0] = i_fft_busy;
         w_view[1] = r_done;
         w_view[2] = r_err;
      end
   end

   // Sticky status: a set in the same cycle as its W1C takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_en      <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_irq         <= 1'b0;
         r_start_pulse <= 1'b0;
         r_ready       <= 1'b0;
         r_rdata       <= '0;
      end else begin
         r_ready       <= bus.wen | bus.ren;
         r_rdata       <= (bus.ren && !bus.wen) ? w_view : '0;
         r_start_pulse <= w_start_ok;
         r_irq         <= r_irq_en & r_done;
         r_done        <= i_fft_done | (r_done & ~w_clr_done);
         r_err         <= w_start_err | (r_err & ~w_clr_err);
         if (w_wr_ctrl) begin
            r_irq_en <= bus.wdata[1];
         end
      end
   end

   assign bus.ready     = r_ready;
   assign bus.rdata     = r_rdata;
   assign o_start_pulse = r_start_pulse;
   assign o_irq         = r_irq;

endmodule
